// File: rtl/cosine_batch_initiator.sv
// cosine_batch_initiator
// Buffers host operands in a small FIFO and feeds them one at a time to an
// external cosine engine. Each answer is captured into a single result
// register that the host drains with a ready handshake.
// Ports:
//   clk, rst               - rising-edge clock, synchronous active-low reset
//   op_wr, op_data         - operand push into the FIFO
//   op_full                - FIFO holds DEPTH entries; pushes are dropped
//   res_valid, res_data    - unread result and its value
//   res_ready              - host accepts res_data
//   eng_start, eng_x       - one-cycle start pulse and operand to the engine
//   eng_ans_ready, eng_ans - engine idle/answer-valid flag and its answer
//   err, err_clr           - sticky acknowledge-timeout flag and its clear
//   done_cnt               - count of captured results, wrapping 255->0
module cosine_batch_initiator #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_wr,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_full,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_x,
  input  logic             eng_ans_ready,
  input  logic [WIDTH-1:0] eng_ans,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       done_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, ACK, BUSY, CAPTURE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [TW-1:0]    tmo_cnt;
  logic             push;
  logic             pop;
  logic             launch;
  logic             timeout;

  // op_full comes straight from the registered occupancy, so a push in the
  // same cycle as a CAPTURE pop still sees the pre-pop fullness.
  assign op_full = (count == (AW+1)'(DEPTH));
  assign push    = op_wr && !op_full;
  assign pop     = (state == CAPTURE);

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    launch    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && eng_ans_ready && !res_valid && !err) begin
          state_nxt = LAUNCH;
          launch    = 1'b1;
        end
      end
      LAUNCH: begin
        eng_start = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        if (!eng_ans_ready) begin
          state_nxt = BUSY;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      BUSY: begin
        if (eng_ans_ready) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= op_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      tmo_cnt   <= '0;
      eng_x     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
      done_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // Head is copied on the IDLE->LAUNCH edge so the operand is already
      // valid while eng_start is high; the entry stays queued until CAPTURE,
      // which lets a timed-out operand be relaunched unchanged.
      if (launch) eng_x <= mem[rd_ptr];

      // Counts ACK cycles that saw eng_ans_ready high; zero on ACK entry.
      if (state == ACK) tmo_cnt <= tmo_cnt + 1'b1;
      else              tmo_cnt <= '0;

      if (state == CAPTURE) begin
        res_data  <= eng_ans;
        res_valid <= 1'b1;
        done_cnt  <= done_cnt + 8'd1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: doc/cosine_batch_initiator.md
COSINE_BATCH_INITIATOR -- requirements
Module: cosine_batch_initiator

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result word width.
REQ-002 Parameter DEPTH, default 4, sets the operand FIFO depth; the value is a power of two.
REQ-003 Parameter TIMEOUT, default 8, sets the maximum cycles to wait for engine acknowledge.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge system clock.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 op_wr  in  1  host pushes op_data into the operand FIFO.
REQ-008 op_data  in  WIDTH  operand x.
REQ-009 op_full  out  1  FIFO holds DEPTH entries.
REQ-010 res_valid  out  1  res_data holds an unread result.
REQ-011 res_data  out  WIDTH  captured cosine result.
REQ-012 res_ready  in  1  host accepts res_data.
REQ-013 eng_start  out  1  start request to the cosine engine.
REQ-014 eng_x  out  WIDTH  operand presented to the engine.
REQ-015 eng_ans_ready  in  1  engine idle/answer-valid flag.
REQ-016 eng_ans  in  WIDTH  engine answer.
REQ-017 err  out  1  sticky acknowledge-timeout flag.
REQ-018 err_clr  in  1  clears err.
REQ-019 done_cnt  out  8  count of completed results, wrapping 255->0.

Function
REQ-020 The FSM SHALL have the states IDLE, LAUNCH, ACK, BUSY and CAPTURE.
REQ-021 IDLE->LAUNCH SHALL occur when the FIFO is non-empty, eng_ans_ready=1, res_valid=0 and err=0; IDLE SHALL be held otherwise.
REQ-022 LAUNCH SHALL assert eng_start=1 for exactly one cycle, load eng_x from the FIFO head, and go to ACK.
REQ-023 ACK SHALL drive eng_start=0 and go to BUSY on the first cycle eng_ans_ready=0; the timeout counter SHALL be cleared on entry to ACK.
REQ-024 In ACK, if eng_ans_ready stays 1 for TIMEOUT consecutive cycles, the block SHALL set err=1 and go to IDLE without popping the FIFO.
REQ-025 BUSY SHALL wait without limit and go to CAPTURE on the first cycle eng_ans_ready=1.
REQ-026 CAPTURE SHALL latch eng_ans into res_data, set res_valid=1, pop the FIFO, increment done_cnt, and go to IDLE in a single cycle.
REQ-027 eng_x SHALL remain stable from LAUNCH until CAPTURE is exited.
REQ-028 res_valid SHALL clear on the cycle after res_valid=1 and res_ready=1; res_data SHALL hold its value until the next CAPTURE.
REQ-029 A push SHALL occur when op_wr=1 and op_full=0, using op_full as registered before any same-cycle pop; a push while full SHALL be dropped silently.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-031 err_clr=1 SHALL clear err on the next edge; if err_clr is asserted in the same cycle that a timeout sets err, the set SHALL win.
REQ-032 Launch-to-result latency SHALL be the engine busy time plus 3 cycles (LAUNCH, ACK, CAPTURE).
REQ-033 The block SHALL NOT launch while res_valid=1, so an unread result is never overwritten.

Reset
REQ-034 When rst=0 at a clock edge, the block SHALL go to IDLE and empty the FIFO, with eng_start=0, eng_x=0, res_valid=0, res_data=0, err=0, done_cnt=0 and op_full=0.
REQ-035 A reset in any state, including mid-transaction, SHALL abandon the transaction and discard the FIFO contents.

Verification
REQ-036 Push x=0x1000 with an engine model that drops ans_ready 1 cycle after start and holds it low for 10 cycles -> eng_start is high for 1 cycle, res_valid rises 13 cycles after LAUNCH, res_data=model value, done_cnt=1.
REQ-037 Push 5 operands back-to-back with res_ready=1 -> op_full rises after the 4th push, the 5th push is dropped, exactly 4 results are delivered in order, done_cnt=4.
REQ-038 Hold res_ready=0 after the first result -> no second eng_start occurs until res_ready=1 is seen, and then the next launch follows within 2 cycles.
REQ-039 Engine ans_ready stuck at 1 -> err=1 exactly TIMEOUT=8 cycles after ACK entry, FIFO occupancy unchanged; after err_clr, the same operand is relaunched.
REQ-040 Assert rst=0 during BUSY with 3 operands queued -> next cycle state is IDLE, FIFO empty, res_valid=0, eng_start=0, done_cnt=0.
REQ-041 Run 256 completed results -> done_cnt wraps to 0.
